// File: rtl/regfile_writer_if.sv
// rtl/regfile_writer_if.sv - write-request handshake bundle for the operand register file
interface regfile_writer_if #(
    parameter int WIDTH = 8
);
    logic             wr_valid;
    logic             wr_ready;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ack;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready,
        input  wr_ack
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready,
        output wr_ack
    );
endinterface

// File: rtl/regfile_writer.sv
// rtl/regfile_writer.sv - 4-entry operand register file with default reload and handshaked writes
module regfile_writer #(
    parameter int             WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT0 = 8'h48,
    parameter logic [WIDTH-1:0] INIT1 = 8'hAF,
    parameter logic [WIDTH-1:0] INIT2 = 8'hCC,
    parameter logic [WIDTH-1:0] INIT3 = 8'h32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    regfile_writer_if.slave  wr,
    output logic             init_done,
    input  logic [1:0]       rd_sel1,
    input  logic [1:0]       rd_sel2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [WIDTH-1:0] reg_c,
    output logic [WIDTH-1:0] reg_d,
    output logic [7:0]       wr_count
);

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t           state;
    logic [1:0]       cnt;
    logic [WIDTH-1:0] regs [4];
    logic             ack_q;
    logic [7:0]       count_q;
    logic             accept;

    function automatic logic [WIDTH-1:0] init_val(input logic [1:0] idx);
        case (idx)
            2'd0:    init_val = INIT0;
            2'd1:    init_val = INIT1;
            2'd2:    init_val = INIT2;
            default: init_val = INIT3;
        endcase
    endfunction

    // clr blocks acceptance in the same cycle it forces the reload
    assign wr.wr_ready = (state == ST_IDLE) && !clr;
    assign accept      = wr.wr_valid && wr.wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_INIT;
            cnt     <= 2'd0;
            ack_q   <= 1'b0;
            count_q <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            ack_q <= 1'b0;
            case (state)
                ST_INIT: begin
                    regs[cnt] <= init_val(cnt);
                    cnt       <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (clr) begin
                        state <= ST_INIT;
                        cnt   <= 2'd0;
                    end else if (accept) begin
                        regs[wr.wr_addr] <= wr.wr_data;
                        count_q          <= count_q + 8'd1;
                        ack_q            <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign wr.wr_ack = ack_q;
    assign wr_count  = count_q;
    assign init_done = (state == ST_IDLE);

    assign rd_data1 = regs[rd_sel1];
    assign rd_data2 = regs[rd_sel2];
    assign reg_a    = regs[0];
    assign reg_b    = regs[1];
    assign reg_c    = regs[2];
    assign reg_d    = regs[3];

endmodule

// File: tb/tb_regfile_writer.sv
// tb/tb_regfile_writer.sv - directed scoreboard bench for regfile_writer
module tb_regfile_writer;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       init_done;
    logic [1:0] rd_sel1, rd_sel2;
    logic [7:0] rd_data1, rd_data2;
    logic [7:0] reg_a, reg_b, reg_c, reg_d;
    logic [7:0] wr_count;

    int         compared   = 0;
    int         mismatched = 0;
    int         ack_seen   = 0;
    logic [7:0] exp_count;
    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] dflt [4] = '{8'h48, 8'hAF, 8'hCC, 8'h32};

    regfile_writer_if #(.WIDTH(8)) wr_if ();

    regfile_writer dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .wr        (wr_if),
        .init_done (init_done),
        .rd_sel1   (rd_sel1),
        .rd_sel2   (rd_sel2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .reg_c     (reg_c),
        .reg_d     (reg_d),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] tap(input logic [1:0] a);
        case (a)
            2'd0:    tap = reg_a;
            2'd1:    tap = reg_b;
            2'd2:    tap = reg_c;
            default: tap = reg_d;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the request until the DUT is ready; the expectation is queued for the ack monitor.
    task automatic write(input logic [1:0] a, input logic [7:0] d, output int waits);
        exp_t e;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = a;
        wr_if.wr_data  = d;
        waits = 0;
        @(negedge clk);
        while (wr_if.wr_ready !== 1'b1 && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (wr_if.wr_ready !== 1'b1) begin
            compared++;
            mismatched++;
            $error("FAIL write_timeout observed=not_ready expected=ready");
            wr_if.wr_valid = 1'b0;
        end else begin
            exp_count++;
            e.addr = a;
            e.data = d;
            e.cnt  = exp_count;
            sb.push_back(e);
        end
        tick();
    endtask

    task automatic check_fill();
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("fill_reg", 32'(tap(i[1:0])), 32'(dflt[i]));
            check("fill_done", 32'(init_done), (i == 3) ? 32'd1 : 32'd0);
            check("fill_ready", 32'(wr_if.wr_ready), (i == 3) ? 32'd1 : 32'd0);
            if (i < 3) check("fill_pending_zero", 32'(tap(2'(i + 1))), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (wr_if.wr_ack === 1'b1) begin
            ack_seen++;
            check("ack_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("ack_reg", 32'(tap(mon_e.addr)), 32'(mon_e.data));
                check("ack_count", 32'(wr_count), 32'(mon_e.cnt));
            end
        end
    end

    initial begin
        int w;
        int stalls;
        rst = 1'b1;
        clr = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = 2'd0;
        wr_if.wr_data  = 8'd0;
        rd_sel1   = 2'd0;
        rd_sel2   = 2'd0;
        exp_count = 8'd0;

        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_reg_a", 32'(reg_a), 32'h00);
        check("rst_reg_d", 32'(reg_d), 32'h00);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_ready", 32'(wr_if.wr_ready), 32'd0);
        check("rst_ack", 32'(wr_if.wr_ack), 32'd0);
        check("rst_count", 32'(wr_count), 32'd0);
        check_fill();

        // back-to-back writes
        tick();
        write(2'd2, 8'h5A, w);
        check("b2b_wait0", 32'(w), 32'd0);
        write(2'd3, 8'h01, w);
        check("b2b_wait1", 32'(w), 32'd0);
        wr_if.wr_valid = 1'b0;
        rd_sel1 = 2'd2;
        rd_sel2 = 2'd3;
        @(negedge clk);
        check("b2b_ack2", 32'(wr_if.wr_ack), 32'd1);
        check("b2b_rd1", 32'(rd_data1), 32'h5A);
        check("b2b_rd2", 32'(rd_data2), 32'h01);
        check("b2b_count", 32'(wr_count), 32'd2);
        tick();
        @(negedge clk);
        check("b2b_ack_low", 32'(wr_if.wr_ack), 32'd0);
        check("b2b_ack_total", 32'(ack_seen), 32'd2);

        // clear against a pending write
        tick();
        clr = 1'b1;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = 2'd0;
        wr_if.wr_data  = 8'hFF;
        @(negedge clk);
        check("clr_ready", 32'(wr_if.wr_ready), 32'd0);
        tick();
        clr = 1'b0;
        @(negedge clk);
        check("clr_no_ack", 32'(wr_if.wr_ack), 32'd0);
        check("clr_a_kept", 32'(reg_a), 32'h48);
        check("clr_c_kept", 32'(reg_c), 32'h5A);
        check("clr_init_done", 32'(init_done), 32'd0);
        write(2'd0, 8'hFF, w);
        check("clr_held_wait", 32'(w), 32'd3);
        wr_if.wr_valid = 1'b0;
        @(negedge clk);
        check("clr_a_written", 32'(reg_a), 32'hFF);
        check("clr_c_reloaded", 32'(reg_c), 32'hCC);
        check("clr_count", 32'(wr_count), 32'd3);

        // reset in the cnt=2 reload cycle
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mid_a_reloaded", 32'(reg_a), 32'h48);
        check("mid_b_reloaded", 32'(reg_b), 32'hAF);
        check("mid_init_done", 32'(init_done), 32'd0);
        tick();
        rst = 1'b0;
        exp_count = 8'd0;
        @(negedge clk);
        check("mid_rst_a", 32'(reg_a), 32'h00);
        check("mid_rst_b", 32'(reg_b), 32'h00);
        check("mid_rst_count", 32'(wr_count), 32'd0);
        check("mid_rst_done", 32'(init_done), 32'd0);
        check_fill();

        // 257 accepted writes across the counter wrap
        tick();
        stalls = 0;
        for (int i = 0; i < 257; i++) begin
            write(i[1:0], 8'(i * 7 + 3), w);
            stalls += w;
        end
        wr_if.wr_valid = 1'b0;
        @(negedge clk);
        check("wrap_stalls", 32'(stalls), 32'd0);
        check("wrap_count", 32'(wr_count), 32'h01);
        tick();
        tick();
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
